// File: rtl/ins_loader_pkg.sv
// Shared definitions for the UART instruction loader: receiver states,
// default timing parameters and the instruction-memory geometry.
package ins_loader_pkg;

    // Receiver frame states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // 50 MHz system clock, 115200 baud
    localparam int DEF_CLKS_PER_BIT = 434;
    // 100 ms of idle line between bytes of one word
    localparam int DEF_TIMEOUT_CYC  = 5_000_000;
    // Instruction memory depth in 32-bit words
    localparam int IMEM_WORDS       = 256;
    localparam int WIDX_W           = $clog2(IMEM_WORDS);

    // Word index to byte address; the upper bits stay zero so the address
    // wraps together with the word index.
    function automatic logic [31:0] word_to_addr(input logic [WIDX_W-1:0] idx);
        return {{(32-WIDX_W-2){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/ins_loader_uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, start-edge detection,
// mid-bit sampling, one-cycle byte-valid and framing-error pulses.
module uart_rx
    import ins_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       data_vld,
    output logic       frm_err,
    output logic       busy
);

    localparam int HALF_BIT = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic             rxd_meta;
    logic             rxd_sync;
    logic             rxd_prev;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_nxt;
    logic [7:0]       shreg;
    logic [7:0]       shreg_nxt;

    // Synchronize the asynchronous line and keep one extra flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // Receiver state, bit-timing counter, bit index and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

    // Next-state logic: sample mid-bit, pulse valid or error on the stop bit
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        data_vld    = 1'b0;
        frm_err     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt     = '0;
                bit_idx_nxt = '0;
                if (rxd_prev && !rxd_sync) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    // A line that is high again by mid start bit was a glitch
                    state_nxt = rxd_sync ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rxd_sync, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    data_vld  = rxd_sync;
                    frm_err   = !rxd_sync;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Disabled loader: abandon any frame in flight and report nothing
        if (clr) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            bit_idx_nxt = '0;
            data_vld    = 1'b0;
            frm_err     = 1'b0;
        end
    end

    assign data = shreg;
    assign busy = (state != IDLE);

endmodule

// File: rtl/ins_loader.sv
// UART instruction loader: gathers four received bytes big-endian into a
// 32-bit word and writes it to consecutive instruction-memory addresses.
module ins_loader
    import ins_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        EN,
    input  logic        RXD,
    output logic [31:0] W_Ins,
    output logic [31:0] W_ADDR,
    output logic        WE,
    output logic        BUSY,
    output logic        ERR,
    output logic [7:0]  WCOUNT
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [7:0]        rx_byte_p0;
    logic              rx_vld_p0;
    logic              rx_err_p0;
    logic              rx_busy;
    logic              byte_acc;
    logic [1:0]        byte_idx;
    logic [23:0]       word_buf;
    logic [TO_W-1:0]   to_cnt;
    logic [WIDX_W-1:0] word_idx;
    logic              vld_p1;
    logic [31:0]       ins_p1;
    logic              err_q;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (CLK),
        .rst_n    (nRST),
        .clr      (!EN),
        .rxd      (RXD),
        .data     (rx_byte_p0),
        .data_vld (rx_vld_p0),
        .frm_err  (rx_err_p0),
        .busy     (rx_busy)
    );

    // Stage p0: a received byte is only taken while the loader is enabled
    assign byte_acc = rx_vld_p0 && EN;

    // Byte index, inter-byte timeout, sticky error, write strobe and word index
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            byte_idx <= '0;
            to_cnt   <= '0;
            err_q    <= 1'b0;
            vld_p1   <= 1'b0;
            word_idx <= '0;
        end else if (!EN) begin
            byte_idx <= '0;
            to_cnt   <= '0;
            err_q    <= 1'b0;
            vld_p1   <= 1'b0;
            word_idx <= '0;
        end else begin
            vld_p1 <= 1'b0;
            // Address advances the cycle after the strobe so it is stable during WE
            if (vld_p1) begin
                word_idx <= word_idx + 1'b1;
            end
            if (byte_acc) begin
                to_cnt   <= '0;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    vld_p1 <= 1'b1;
                end
            end else if (byte_idx != 2'd0) begin
                if (to_cnt == TO_LAST) begin
                    // Stale partial word: drop it, keep the write address
                    byte_idx <= '0;
                    to_cnt   <= '0;
                    err_q    <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
            if (rx_err_p0) begin
                err_q <= 1'b1;
            end
        end
    end

    // Collect the leading three bytes of a word, oldest ending up in the top byte
    always_ff @(posedge CLK) begin
        if (byte_acc) begin
            word_buf <= {word_buf[15:0], rx_byte_p0};
        end
    end

    // Stage p1: the completed word is published only together with its strobe
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ins_p1 <= '0;
        end else if (byte_acc && (byte_idx == 2'd3)) begin
            ins_p1 <= {word_buf, rx_byte_p0};
        end
    end

    assign W_Ins  = ins_p1;
    assign WE     = vld_p1 && EN;
    assign W_ADDR = word_to_addr(word_idx);
    assign WCOUNT = word_idx;
    assign BUSY   = rx_busy || (byte_idx != 2'd0);
    assign ERR    = err_q;

endmodule
